// File: rtl/config_chain_loader_pkg.sv
// rtl/config_chain_loader_pkg.sv - shared types and helpers for the configuration chain loader
//
// Purpose: FSM state encoding, operation mode constants and a word-count helper
//          used by the loader and by anything that needs to size a bitstream.
// Ports:   none (package).

package config_chain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_RB_SHIFT,
      ST_RB_PUSH,
      ST_DONE
   } state_t;

   localparam logic MODE_WRITE    = 1'b0;
   localparam logic MODE_READBACK = 1'b1;

   // Number of bitstream words needed to cover the whole chain.
   function automatic int unsigned word_count(input int unsigned chain_len,
                                              input int unsigned word_width);
      return (chain_len + word_width - 1) / word_width;
   endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// rtl/config_chain_loader_if.sv - control, bitstream and chain signals of the configuration chain loader
//
// Purpose: bundles every loader signal except clock and reset.
// Ports (slave = loader side):
//   start, mode            in   begin an operation / write(0) or readback(1)
//   busy, done             out  operation in progress / one-cycle end pulse
//   wr_data/valid/ready    bitstream words into the loader, LSB shifted first
//   rd_data/valid/ready    readback words out of the loader
//   chain_data, chain_en   out  to config_in / config_en of the chain
//   chain_return           in   from config_out of the last chain element

interface config_chain_loader_if #(
   parameter int WORD_WIDTH = 8
);
   logic                  start;
   logic                  mode;
   logic                  busy;
   logic                  done;
   logic [WORD_WIDTH-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [WORD_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic                  chain_data;
   logic                  chain_en;
   logic                  chain_return;

   modport master (
      output start, mode, wr_data, wr_valid, rd_ready, chain_return,
      input  busy, done, wr_ready, rd_data, rd_valid, chain_data, chain_en
   );

   modport slave (
      input  start, mode, wr_data, wr_valid, rd_ready, chain_return,
      output busy, done, wr_ready, rd_data, rd_valid, chain_data, chain_en
   );
endinterface

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serial configuration chain writer and non-destructive reader
//
// Purpose: write mode serialises bitstream words into the chain; readback mode
//          circulates the chain once, returning its contents as words while
//          leaving the configuration unchanged.
// Ports:
//   config_clk  in  configuration clock, all state on the rising edge
//   sys_reset   in  synchronous active-low reset
//   bus         config_chain_loader_if.slave (see interface header)

module config_chain_loader
   import config_chain_pkg::*;
#(
   parameter int CHAIN_LEN  = 16,
   parameter int WORD_WIDTH = 8
) (
   input  logic                 config_clk,
   input  logic                 sys_reset,
   config_chain_loader_if.slave bus
);

   localparam int BW  = $clog2(CHAIN_LEN + 1);
   localparam int WBW = $clog2(WORD_WIDTH);
   localparam logic [BW-1:0]  LAST_BIT  = BW'(CHAIN_LEN);
   localparam logic [WBW-1:0] LAST_WBIT = WBW'(WORD_WIDTH - 1);

   state_t                state_q, state_d;
   logic [BW-1:0]         bit_cnt;
   logic [WBW-1:0]        word_bit;
   logic [WORD_WIDTH-1:0] shreg;
   logic [WORD_WIDTH-1:0] rd_shreg;
   logic                  chain_last;
   logic                  word_last;

   logic busy_c, done_c, wr_ready_c, rd_valid_c, chain_en_c, chain_data_c;

   // Both flags describe the shift happening in the current cycle.
   assign chain_last = (bit_cnt + BW'(1)) == LAST_BIT;
   assign word_last  = word_bit == LAST_WBIT;

   always_ff @(posedge config_clk) begin
      if (!sys_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      busy_c       = 1'b1;
      done_c       = 1'b0;
      wr_ready_c   = 1'b0;
      rd_valid_c   = 1'b0;
      chain_en_c   = 1'b0;
      chain_data_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               state_d = (bus.mode == MODE_READBACK) ? ST_RB_SHIFT : ST_FETCH;
            end
         end
         ST_FETCH: begin
            // chain_en stays low so the chain holds while we wait for a word
            wr_ready_c = 1'b1;
            if (bus.wr_valid) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            chain_en_c   = 1'b1;
            chain_data_c = shreg[0];
            if (chain_last)     state_d = ST_DONE;
            else if (word_last) state_d = ST_FETCH;
         end
         ST_RB_SHIFT: begin
            // feeding the returned bit back in restores the chain after CHAIN_LEN shifts
            chain_en_c   = 1'b1;
            chain_data_c = bus.chain_return;
            if (chain_last || word_last) state_d = ST_RB_PUSH;
         end
         ST_RB_PUSH: begin
            rd_valid_c = 1'b1;
            if (bus.rd_ready) begin
               state_d = (bit_cnt == LAST_BIT) ? ST_DONE : ST_RB_SHIFT;
            end
         end
         ST_DONE: begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge config_clk) begin
      if (!sys_reset) begin
         bit_cnt  <= '0;
         word_bit <= '0;
         shreg    <= '0;
         rd_shreg <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  bit_cnt  <= '0;
                  word_bit <= '0;
                  rd_shreg <= '0;
               end
            end
            ST_FETCH: begin
               if (bus.wr_valid) begin
                  shreg    <= bus.wr_data;
                  word_bit <= '0;
               end
            end
            ST_SHIFT: begin
               shreg    <= shreg >> 1;
               bit_cnt  <= bit_cnt + BW'(1);
               word_bit <= word_last ? '0 : word_bit + WBW'(1);
            end
            ST_RB_SHIFT: begin
               // rd_shreg was cleared beforehand, so a short final word is zero-padded
               rd_shreg[word_bit] <= bus.chain_return;
               bit_cnt            <= bit_cnt + BW'(1);
               word_bit           <= (word_last || chain_last) ? '0 : word_bit + WBW'(1);
            end
            ST_RB_PUSH: begin
               if (bus.rd_ready) rd_shreg <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.wr_ready   = wr_ready_c;
   assign bus.rd_valid   = rd_valid_c;
   assign bus.chain_en   = chain_en_c;
   assign bus.chain_data = chain_data_c;
   assign bus.rd_data    = rd_shreg;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - scoreboard testbench for config_chain_loader

module tb_config_chain_loader;
   import config_chain_pkg::*;

   localparam int WW = 8;
   localparam int L0 = 16;
   localparam int L1 = 12;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   config_chain_loader_if #(.WORD_WIDTH(WW)) bus0 ();
   config_chain_loader_if #(.WORD_WIDTH(WW)) bus1 ();

   config_chain_loader #(.CHAIN_LEN(L0), .WORD_WIDTH(WW)) dut0 (
      .config_clk (clk),
      .sys_reset  (rstn),
      .bus        (bus0)
   );

   config_chain_loader #(.CHAIN_LEN(L1), .WORD_WIDTH(WW)) dut1 (
      .config_clk (clk),
      .sys_reset  (rstn),
      .bus        (bus1)
   );

   // behavioural chains: one flop per configuration bit, element 0 nearest the loader
   logic [L0-1:0] model0 = '0;
   logic [L1-1:0] model1 = '0;
   always @(posedge clk) begin
      if (bus0.chain_en) model0 <= {model0[L0-2:0], bus0.chain_data};
      if (bus1.chain_en) model1 <= {model1[L1-2:0], bus1.chain_data};
   end
   assign bus0.chain_return = model0[L0-1];
   assign bus1.chain_return = model1[L1-1];

   // per-instance stimulus and observation arrays
   logic          start_v [2];
   logic          mode_v [2];
   logic [WW-1:0] wr_data_v [2];
   logic          wr_valid_v [2];
   logic          rd_ready_v [2];
   logic          busy_v [2], done_v [2], wr_ready_v [2], rd_valid_v [2];
   logic          chain_en_v [2], chain_data_v [2], chain_ret_v [2];
   logic [WW-1:0] rd_data_v [2];

   assign bus0.start = start_v[0];       assign bus1.start = start_v[1];
   assign bus0.mode = mode_v[0];         assign bus1.mode = mode_v[1];
   assign bus0.wr_data = wr_data_v[0];   assign bus1.wr_data = wr_data_v[1];
   assign bus0.wr_valid = wr_valid_v[0]; assign bus1.wr_valid = wr_valid_v[1];
   assign bus0.rd_ready = rd_ready_v[0]; assign bus1.rd_ready = rd_ready_v[1];

   assign busy_v[0] = bus0.busy;             assign busy_v[1] = bus1.busy;
   assign done_v[0] = bus0.done;             assign done_v[1] = bus1.done;
   assign wr_ready_v[0] = bus0.wr_ready;     assign wr_ready_v[1] = bus1.wr_ready;
   assign rd_valid_v[0] = bus0.rd_valid;     assign rd_valid_v[1] = bus1.rd_valid;
   assign chain_en_v[0] = bus0.chain_en;     assign chain_en_v[1] = bus1.chain_en;
   assign chain_data_v[0] = bus0.chain_data; assign chain_data_v[1] = bus1.chain_data;
   assign chain_ret_v[0] = bus0.chain_return; assign chain_ret_v[1] = bus1.chain_return;
   assign rd_data_v[0] = bus0.rd_data;       assign rd_data_v[1] = bus1.rd_data;

   int   n_run  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   t_start;
   int   en_cnt [2];
   int   done_cnt [2];
   logic op_rb [2];

   bit            q_bits0 [$];
   bit            q_bits1 [$];
   logic [WW-1:0] q_words0 [$];
   logic [WW-1:0] q_words1 [$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void push_bit(input int s, input bit b);
      if (s == 0) q_bits0.push_back(b); else q_bits1.push_back(b);
   endfunction
   function automatic int bits_left(input int s);
      return (s == 0) ? q_bits0.size() : q_bits1.size();
   endfunction
   function automatic bit pop_bit(input int s);
      if (s == 0) return q_bits0.pop_front();
      return q_bits1.pop_front();
   endfunction
   function automatic void push_word(input int s, input logic [WW-1:0] w);
      if (s == 0) q_words0.push_back(w); else q_words1.push_back(w);
   endfunction
   function automatic int words_left(input int s);
      return (s == 0) ? q_words0.size() : q_words1.size();
   endfunction
   function automatic logic [WW-1:0] pop_word(input int s);
      if (s == 0) return q_words0.pop_front();
      return q_words1.pop_front();
   endfunction
   function automatic logic [L0-1:0] model_of(input int s);
      return (s == 0) ? model0 : {{(L0-L1){1'b0}}, model1};
   endfunction
   function automatic logic [13:0] outs(input int s);
      return {busy_v[s], done_v[s], wr_ready_v[s], rd_valid_v[s],
              chain_en_v[s], chain_data_v[s], rd_data_v[s]};
   endfunction
   function automatic logic sig(input int s, input int k);
      case (k)
         0:       return wr_ready_v[s];
         1:       return rd_valid_v[s];
         default: return done_v[s];
      endcase
   endfunction

   // monitor: consumes expected bits/words whenever the DUT presents them
   task automatic mon_one(input int s);
      if (chain_en_v[s]) en_cnt[s]++;
      if (done_v[s])     done_cnt[s]++;
      if (wr_ready_v[s]) chk("fetch_holds_chain", 32'(chain_en_v[s]), 0);
      if (chain_en_v[s] && !op_rb[s]) begin
         if (bits_left(s) == 0) chk("unexpected_chain_bit", 1, 0);
         else chk("chain_data", 32'(chain_data_v[s]), 32'(pop_bit(s)));
      end
      if (chain_en_v[s] && op_rb[s])
         chk("recirculate", 32'(chain_data_v[s]), 32'(chain_ret_v[s]));
      if (rd_valid_v[s] && rd_ready_v[s]) begin
         if (words_left(s) == 0) chk("unexpected_rd_word", 1, 0);
         else chk("rd_data", 32'(rd_data_v[s]), 32'(pop_word(s)));
      end
   endtask

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) mon_one(s);
   end

   task automatic wait_sig(input int s, input int k, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sig(s, k) && n < 200);
      if (!sig(s, k)) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic start_op(input int s, input logic m);
      @(posedge clk); #1;
      start_v[s] = 1'b1;
      mode_v[s]  = m;
      op_rb[s]   = m;
      t_start    = cyc;
      @(posedge clk); #1;
      start_v[s] = 1'b0;
   endtask

   task automatic do_write(input int s, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input int gap, input bit check_time);
      int            len  = (s == 0) ? L0 : L1;
      int            e0   = en_cnt[s];
      int            d0   = done_cnt[s];
      int            t0;
      logic [2*WW-1:0] bits = {w1, w0};
      logic [L0-1:0]   snap;
      for (int i = 0; i < len; i++) push_bit(s, bits[i]);
      wr_data_v[s]  = w0;
      wr_valid_v[s] = 1'b1;
      start_op(s, MODE_WRITE);
      t0 = t_start;
      wait_sig(s, 0, "fetch_w0");
      @(posedge clk); #1;
      wr_data_v[s] = w1;
      if (gap > 0) wr_valid_v[s] = 1'b0;
      wait_sig(s, 0, "fetch_w1");
      if (gap > 0) begin
         snap = model_of(s);
         for (int g = 0; g < gap; g++) begin
            if (g > 0) @(negedge clk);
            chk("gap_chain_en", 32'(chain_en_v[s]), 0);
            chk("gap_model_hold", 32'(model_of(s)), 32'(snap));
         end
         @(posedge clk); #1;
         wr_valid_v[s] = 1'b1;
      end
      @(posedge clk); #1;
      wr_valid_v[s] = 1'b0;
      wait_sig(s, 2, "write_done");
      if (check_time) chk("write_latency", cyc - t0, L0 + 2 + 1);
      @(negedge clk);
      chk("write_en_cycles", en_cnt[s] - e0, len);
      chk("write_done_pulses", done_cnt[s] - d0, 1);
      chk("write_bits_left", bits_left(s), 0);
      chk("idle_after_write", 32'(busy_v[s]), 0);
   endtask

   task automatic do_readback(input int s, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                              input int hold);
      int            len  = (s == 0) ? L0 : L1;
      int            e0   = en_cnt[s];
      int            d0   = done_cnt[s];
      logic [L0-1:0] snap = model_of(s);
      logic [WW-1:0] hsnap;
      if (word_count(len, WW) > 0) push_word(s, w0);
      if (word_count(len, WW) > 1) push_word(s, w1);
      rd_ready_v[s] = (hold == 0);
      start_op(s, MODE_READBACK);
      if (hold > 0) begin
         wait_sig(s, 1, "rb_first_word");
         hsnap = rd_data_v[s];
         for (int h = 0; h < hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("hold_rd_valid", 32'(rd_valid_v[s]), 1);
            chk("hold_rd_data", 32'(rd_data_v[s]), 32'(hsnap));
            chk("hold_chain_en", 32'(chain_en_v[s]), 0);
         end
         @(posedge clk); #1;
         rd_ready_v[s] = 1'b1;
      end
      wait_sig(s, 2, "rb_done");
      @(negedge clk);
      chk("rb_en_cycles", en_cnt[s] - e0, len);
      chk("rb_done_pulses", done_cnt[s] - d0, 1);
      chk("rb_words_left", words_left(s), 0);
      chk("rb_chain_restored", 32'(model_of(s)), 32'(snap));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int s = 0; s < 2; s++) begin
         start_v[s] = 1'b0; mode_v[s] = 1'b0; wr_data_v[s] = '0;
         wr_valid_v[s] = 1'b0; rd_ready_v[s] = 1'b0;
         en_cnt[s] = 0; done_cnt[s] = 0; op_rb[s] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_16", 32'(outs(0)), 0);
      chk("reset_outputs_12", 32'(outs(1)), 0);
      @(posedge clk); #1;
      rstn = 1'b1;

      // plain write: bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; first bit ends at the far end
      do_write(0, 8'hA5, 8'h3C, 0, 1'b1);
      chk("t1_chain_contents", 32'(model0), 32'h0000_A53C);
      do_readback(0, 8'hA5, 8'h3C, 0);

      // backpressure on both sides
      do_write(0, 8'h96, 8'h69, 5, 1'b0);
      do_readback(0, 8'h96, 8'h69, 4);

      // short chain: upper nibble of the last word dropped, readback zero-padded
      do_write(1, 8'hFF, 8'h5F, 0, 1'b0);
      chk("t4_chain_contents", 32'(model1), 32'h0000_0FFF);
      do_readback(1, 8'hFF, 8'h0F, 0);

      // reset during a write after five shifts
      for (int i = 0; i < L0; i++) push_bit(0, i < 8 ? 1'((8'h5A >> i) & 1) : 1'((8'hC3 >> (i - 8)) & 1));
      wr_data_v[0]  = 8'h5A;
      wr_valid_v[0] = 1'b1;
      start_op(0, MODE_WRITE);
      wait_sig(0, 0, "t5_fetch");
      @(posedge clk); #1;
      wr_valid_v[0] = 1'b0;
      n = 0;
      for (int g = 0; g < 50 && n < 4; g++) begin
         @(negedge clk);
         if (chain_en_v[0]) n++;
      end
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t5_reset_outputs", 32'(outs(0)), 0);
      chk("t5_bits_shifted", bits_left(0), L0 - 5);
      q_bits0.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      do_write(0, 8'h12, 8'h34, 0, 1'b0);
      do_readback(0, 8'h12, 8'h34, 0);

      // start during SHIFT must be ignored
      fork
         do_write(0, 8'hC3, 8'h18, 0, 1'b0);
         begin
            int k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!chain_en_v[0] && k < 100);
            @(posedge clk); #1;
            start_v[0] = 1'b1;
            mode_v[0]  = MODE_WRITE;
            @(posedge clk); #1;
            start_v[0] = 1'b0;
         end
      join
      n = done_cnt[0];
      repeat (3) @(negedge clk);
      chk("t6_no_extra_done", done_cnt[0] - n, 0);
      chk("t6_idle", 32'(busy_v[0]), 0);
      do_readback(0, 8'hC3, 8'h18, 0);

      // start coinciding with reset
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      mode_v[0]  = MODE_WRITE;
      rstn       = 1'b0;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      rstn       = 1'b1;
      @(negedge clk);
      chk("t6_reset_start_busy", 32'(busy_v[0]), 0);
      chk("t6_reset_start_fetch", 32'(wr_ready_v[0]), 0);
      @(negedge clk);
      chk("t6_reset_start_still_idle", 32'(busy_v[0]), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
